sr04_echo_emulator: RTL and testbench
=====================================

SR04_ECHO_EMULATOR -- requirements
Module: sr04_echo_emulator

Interface
REQ-001 Parameter TRIG_MIN_US, 10: minimum trig high width, in usec ticks, accepted as a valid trigger.
REQ-002 Parameter BURST_DELAY_US, 200: delay from trig fall to echo rise, in usec ticks.
REQ-003 Parameter US_PER_CM, 58: echo usec ticks per cm.
REQ-004 Parameter MAX_CM, 400: largest cm_value emulated as an in-range distance.
REQ-005 Parameter TIMEOUT_US, 38000: echo width for out-of-range distances.
REQ-006 Parameter HOLDOFF_US, 60000: dead time after echo fall, in usec ticks.
REQ-007 clk  in  1  system clock (100 MHz); all logic on posedge clk only.
REQ-008 reset_p  in  1  reset, synchronous, active-high.
REQ-009 clk_usec  in  1  one-clk-wide tick, once per usec.
REQ-010 trig  in  1  asynchronous trigger from the initiator.
REQ-011 cm_value  in  12  distance to emulate, in cm.
REQ-012 echo  out  1  emulated echo pulse, registered.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 trig_err  out  1  one-clk pulse when a trigger is rejected as too short.

Function
REQ-015 trig SHALL pass through a 2-flop synchronizer; all trig behaviour below refers to the synchronized signal (2-clk latency).
REQ-016 FSM states SHALL be IDLE, TRIG, BURST, ECHO, HOLDOFF.
REQ-017 IDLE -> TRIG on a trig rising edge; a trig already high on entry to IDLE SHALL NOT start a cycle.
REQ-018 In TRIG, a saturating counter SHALL count clk_usec ticks while trig is high.
REQ-019 On trig fall in TRIG: if count >= TRIG_MIN_US, latch cm_value and go to BURST; otherwise pulse trig_err for 1 clk and return to IDLE.
REQ-020 BURST SHALL count BURST_DELAY_US ticks, then go to ECHO with echo=1 on the following clk.
REQ-021 Echo high time SHALL be exactly cm_latched*US_PER_CM ticks when 1 <= cm_latched <= MAX_CM, else TIMEOUT_US ticks.
REQ-022 The width product SHALL be computed at >= 20 bits with no truncation.
REQ-023 The clk after the last echo tick, echo SHALL go 0 and the FSM SHALL enter HOLDOFF.
REQ-024 HOLDOFF SHALL count HOLDOFF_US ticks and ignore trig, then return to IDLE.
REQ-025 cm_value changes after the latch point SHALL NOT affect the current echo.
REQ-026 Trig activity in BURST, ECHO or HOLDOFF SHALL be ignored and SHALL NOT pulse trig_err.
REQ-027 All usec counters SHALL advance only on clk cycles where clk_usec=1.

Reset
REQ-028 While reset_p=1 at a clk edge: state=IDLE, echo=0, busy=0, trig_err=0, all counters, the synchronizer and cm_latched = 0.
REQ-029 Reset asserted mid-ECHO SHALL drop echo at that same clk edge, with no holdoff afterwards.
REQ-030 After reset release, a trig that is already high SHALL need a fresh rising edge to start a cycle.

Structure
REQ-031 The default values of TRIG_MIN_US, US_PER_CM, MAX_CM, TIMEOUT_US and the FSM state encoding SHALL live in a shared sr04_pkg.
REQ-032 The trig rising/falling edge detection SHALL use one sub-module instance, edge_detector_p, after the synchronizer; all other logic stays flat.

Verification (bench params: BURST_DELAY_US=5, HOLDOFF_US=20, TIMEOUT_US=100, US_PER_CM=58, clk_usec every 100 clk)
REQ-033 Trig high for 12 usec, cm_value=3 -> echo rises 5 ticks after trig fall, high for exactly 174 ticks, busy=1 throughout, trig_err stays 0.
REQ-034 Trig high for 4 usec -> a single 1-clk trig_err pulse, echo stays 0, FSM back in IDLE.
REQ-035 cm_value=0, then a separate run with cm_value=401 -> each echo is 100 ticks wide.
REQ-036 cm_value changed 3->9 mid-echo, plus a second trig pulse during HOLDOFF -> echo width stays 174 ticks, no second echo, and a trig after holdoff produces a new echo.
REQ-037 reset_p pulsed mid-ECHO -> echo=0 and busy=0 at that edge; a trig held high through release produces no echo until it falls and rises again.

Source files
------------

// File: rtl/sr04_pkg.sv
// Shared defaults, FSM encoding and echo-width helper for the SR04 echo emulator.
package sr04_pkg;

  localparam int TRIG_MIN_US_DEF    = 10;
  localparam int BURST_DELAY_US_DEF = 200;
  localparam int US_PER_CM_DEF      = 58;
  localparam int MAX_CM_DEF         = 400;
  localparam int TIMEOUT_US_DEF     = 38000;
  localparam int HOLDOFF_US_DEF     = 60000;

  localparam int CNT_W = 24;
  localparam int CM_W  = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG    = 3'd1,
    ST_BURST   = 3'd2,
    ST_ECHO    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  // 4095 * 58 needs 18 bits, so a 24-bit product never truncates.
  function automatic logic [CNT_W-1:0] echo_ticks(input logic [CM_W-1:0] cm,
                                                  input int us_per_cm,
                                                  input int max_cm,
                                                  input int timeout_us);
    logic [CNT_W-1:0] cm_w;
    cm_w = CNT_W'(cm);
    if ((cm_w != '0) && (cm_w <= CNT_W'(max_cm))) begin
      echo_ticks = cm_w * CNT_W'(us_per_cm);
    end else begin
      echo_ticks = CNT_W'(timeout_us);
    end
  endfunction

endpackage

// File: rtl/sr04_echo_emulator_edge.sv
// Rising/falling edge detector for an already-synchronized level, combinational
// outputs one clk wide relative to the registered previous sample.
module edge_detector_p (
  input  logic clk,
  input  logic reset_p,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = sig;
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = sig & ~prev_q;
  assign fall = ~sig & prev_q;

endmodule

// File: rtl/sr04_echo_emulator.sv
// HC-SR04 echo emulator: validates trig width, waits the burst delay, then drives
// a registered echo pulse of cm*US_PER_CM usec (or timeout) followed by a dead time.
module sr04_echo_emulator
  import sr04_pkg::*;
#(
  parameter int TRIG_MIN_US    = TRIG_MIN_US_DEF,
  parameter int BURST_DELAY_US = BURST_DELAY_US_DEF,
  parameter int US_PER_CM      = US_PER_CM_DEF,
  parameter int MAX_CM         = MAX_CM_DEF,
  parameter int TIMEOUT_US     = TIMEOUT_US_DEF,
  parameter int HOLDOFF_US     = HOLDOFF_US_DEF
) (
  input  logic            clk,
  input  logic            reset_p,
  input  logic            clk_usec,
  input  logic            trig,
  input  logic [CM_W-1:0] cm_value,
  output logic            echo,
  output logic            busy,
  output logic            trig_err
);

  logic             trig_meta_q, trig_meta_d;
  logic             trig_sync_q, trig_sync_d;
  logic [1:0]       sync_vld_q, sync_vld_d;
  logic             armed_q, armed_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CM_W-1:0]  cm_latched_q, cm_latched_d;
  logic             echo_q, echo_d;
  logic             trig_err_q, trig_err_d;

  logic             trig_rise;
  logic             trig_fall;
  logic [CNT_W-1:0] echo_len;
  logic             cnt_at_max;

  edge_detector_p u_edge_detector_p (
    .clk     (clk),
    .reset_p (reset_p),
    .sig     (trig_sync_q),
    .rise    (trig_rise),
    .fall    (trig_fall)
  );

  assign echo_len   = echo_ticks(cm_latched_q, US_PER_CM, MAX_CM, TIMEOUT_US);
  assign cnt_at_max = (cnt_q == '1);

  always_comb begin
    trig_meta_d  = trig;
    trig_sync_d  = trig_meta_q;
    // Only a genuinely sampled low arms the detector, so the reset-flushed zeros
    // in the synchronizer cannot fake a rising edge on a trig held across reset.
    sync_vld_d   = {sync_vld_q[0], 1'b1};
    armed_d      = armed_q | (sync_vld_q[1] & ~trig_sync_q);
    state_d      = state_q;
    cnt_d        = cnt_q;
    cm_latched_d = cm_latched_q;
    echo_d       = echo_q;
    trig_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig_rise && armed_q) begin
          state_d = ST_TRIG;
          cnt_d   = '0;
        end
      end
      ST_TRIG: begin
        if (trig_fall) begin
          cnt_d = '0;
          if (cnt_q >= CNT_W'(TRIG_MIN_US)) begin
            cm_latched_d = cm_value;
            state_d      = ST_BURST;
          end else begin
            trig_err_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else if (clk_usec && !cnt_at_max) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BURST: begin
        if (clk_usec) begin
          if (cnt_q == CNT_W'(BURST_DELAY_US - 1)) begin
            state_d = ST_ECHO;
            echo_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ECHO: begin
        if (clk_usec) begin
          if (cnt_q == echo_len - 1'b1) begin
            state_d = ST_HOLDOFF;
            echo_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_HOLDOFF: begin
        if (clk_usec) begin
          if (cnt_q == CNT_W'(HOLDOFF_US - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        echo_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      trig_meta_q  <= 1'b0;
      trig_sync_q  <= 1'b0;
      sync_vld_q   <= 2'b00;
      armed_q      <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cm_latched_q <= '0;
      echo_q       <= 1'b0;
      trig_err_q   <= 1'b0;
    end else begin
      trig_meta_q  <= trig_meta_d;
      trig_sync_q  <= trig_sync_d;
      sync_vld_q   <= sync_vld_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cm_latched_q <= cm_latched_d;
      echo_q       <= echo_d;
      trig_err_q   <= trig_err_d;
    end
  end

  assign echo     = echo_q;
  assign busy     = (state_q != ST_IDLE);
  assign trig_err = trig_err_q;

endmodule

// File: tb/tb_sr04_echo_emulator.sv
// Directed-with-random-values bench: a negedge monitor records echo pulses in
// clocks and usec ticks; expectations come from the distance-to-width rules.
module tb_sr04_echo_emulator;

  localparam int TMIN  = 10;
  localparam int BURST = 5;
  localparam int UPC   = 58;
  localparam int MAXC  = 400;
  localparam int TMO   = 100;
  localparam int HOLD  = 20;
  localparam int CLK_PER_US = 100;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        clk_usec = 1'b0;
  logic        trig;
  logic [11:0] cm_value;
  logic        echo;
  logic        busy;
  logic        trig_err;

  int total = 0;
  int bad   = 0;

  int tick_total  = 0;
  int echo_cnt    = 0;
  int hi_clks     = 0;
  int err_pulses  = 0;
  int err_run     = 0;
  int err_run_max = 0;
  int busy_bad    = 0;
  int echo_w[$];
  int echo_rt[$];
  logic echo_prev = 1'b0;

  sr04_echo_emulator #(
    .TRIG_MIN_US    (TMIN),
    .BURST_DELAY_US (BURST),
    .US_PER_CM      (UPC),
    .MAX_CM         (MAXC),
    .TIMEOUT_US     (TMO),
    .HOLDOFF_US     (HOLD)
  ) dut (
    .clk      (clk),
    .reset_p  (reset_p),
    .clk_usec (clk_usec),
    .trig     (trig),
    .cm_value (cm_value),
    .echo     (echo),
    .busy     (busy),
    .trig_err (trig_err)
  );

  always #5 clk = ~clk;

  initial begin : usec_gen
    forever begin
      repeat (CLK_PER_US - 1) @(posedge clk);
      #2 clk_usec = 1'b1;
      @(posedge clk);
      #2 clk_usec = 1'b0;
    end
  end

  always @(negedge clk) begin : monitor
    if (clk_usec) tick_total++;
    if (echo && !echo_prev) begin
      echo_cnt++;
      echo_rt.push_back(tick_total);
      hi_clks = 0;
    end
    if (echo) hi_clks++;
    if (!echo && echo_prev) echo_w.push_back(hi_clks);
    if (echo && !busy) busy_bad++;
    if (trig_err) begin
      err_pulses++;
      err_run++;
      if (err_run > err_run_max) err_run_max = err_run;
    end else begin
      err_run = 0;
    end
    echo_prev = echo;
  end

  // Reference: in-range distances give cm*US_PER_CM usec, anything else the timeout.
  function automatic int model_ticks(input int cm);
    return (cm >= 1 && cm <= MAXC) ? cm * UPC : TMO;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic align_after_tick();
    int c;
    c = 0;
    while (!clk_usec && c < 2 * CLK_PER_US) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
  endtask

  // Trig is raised just after a tick, so the DUT counts exactly k ticks while high.
  task automatic trig_pulse(input int k, output int fall_tick);
    align_after_tick();
    trig = 1'b1;
    repeat (k * CLK_PER_US) @(negedge clk);
    trig = 1'b0;
    fall_tick = tick_total;
  endtask

  task automatic wait_rise(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (echo_cnt < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, int'(echo_cnt >= n), 1);
  endtask

  task automatic wait_width(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (echo_w.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, int'(echo_w.size() >= n), 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c;
    c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, int'(busy), 0);
  endtask

  initial begin : main
    int ft;
    int k;
    int cm;
    int base_echo;

    reset_p  = 1'b1;
    trig     = 1'b0;
    cm_value = 12'd3;
    repeat (3) @(negedge clk);
    chk("reset_echo", int'(echo), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_trig_err", int'(trig_err), 0);
    reset_p = 1'b0;
    repeat (5) @(negedge clk);

    // cm=3, changed to 9 mid-echo, plus a trig pulse inside holdoff
    k = TMIN + int'($urandom_range(0, 4));
    trig_pulse(k, ft);
    wait_rise(1, 20 * CLK_PER_US, "run1_rise");
    repeat (20 * CLK_PER_US) @(negedge clk);
    cm_value = 12'd9;
    wait_width(1, 400 * CLK_PER_US, "run1_fall");
    chk("run1_width", echo_w[0], model_ticks(3) * CLK_PER_US);
    chk("run1_delay", echo_rt[0] - ft, BURST);
    trig = 1'b1;
    repeat (12 * CLK_PER_US) @(negedge clk);
    trig = 1'b0;
    wait_idle(15 * CLK_PER_US, "run1_holdoff_end");
    repeat (10 * CLK_PER_US) @(negedge clk);
    chk("holdoff_trig_ignored", echo_cnt, 1);
    chk("holdoff_no_err", err_pulses, 0);

    // out-of-range distance above MAX_CM
    cm = 401 + int'($urandom_range(0, 4095 - 401));
    cm_value = 12'(cm);
    k = TMIN + int'($urandom_range(0, 4));
    trig_pulse(k, ft);
    wait_width(2, (BURST + TMO + 10) * CLK_PER_US, "run2_fall");
    chk("run2_width", echo_w[1], model_ticks(cm) * CLK_PER_US);
    chk("run2_delay", echo_rt[1] - ft, BURST);
    wait_idle((HOLD + 5) * CLK_PER_US, "run2_idle");

    // zero distance
    cm_value = 12'd0;
    k = TMIN + int'($urandom_range(0, 4));
    trig_pulse(k, ft);
    wait_width(3, (BURST + TMO + 10) * CLK_PER_US, "run3_fall");
    chk("run3_width", echo_w[2], model_ticks(0) * CLK_PER_US);
    wait_idle((HOLD + 5) * CLK_PER_US, "run3_idle");

    // too-short trigger
    base_echo = echo_cnt;
    k = int'($urandom_range(1, TMIN - 1));
    trig_pulse(k, ft);
    repeat (20) @(negedge clk);
    chk("short_err_count", err_pulses, 1);
    chk("short_err_width", err_run_max, 1);
    chk("short_back_idle", int'(busy), 0);
    repeat (10 * CLK_PER_US) @(negedge clk);
    chk("short_no_echo", echo_cnt, base_echo);

    // reset mid-echo with trig held high across release
    cm_value = 12'd0;
    trig_pulse(TMIN + 2, ft);
    wait_rise(base_echo + 1, 20 * CLK_PER_US, "run4_rise");
    repeat (int'($urandom_range(10, 50)) * CLK_PER_US) @(negedge clk);
    trig    = 1'b1;
    reset_p = 1'b1;
    @(negedge clk);
    chk("midecho_reset_echo", int'(echo), 0);
    chk("midecho_reset_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
    repeat (30 * CLK_PER_US) @(negedge clk);
    chk("held_trig_no_echo", echo_cnt, base_echo + 1);
    chk("held_trig_idle", int'(busy), 0);
    trig = 1'b0;
    repeat (10) @(negedge clk);
    cm_value = 12'd1;
    trig_pulse(TMIN + int'($urandom_range(0, 4)), ft);
    wait_width(5, (BURST + UPC + 10) * CLK_PER_US, "run5_fall");
    chk("run5_width", echo_w[4], model_ticks(1) * CLK_PER_US);
    chk("run5_delay", echo_rt[4] - ft, BURST);
    chk("busy_during_echo", busy_bad, 0);
    chk("total_err_pulses", err_pulses, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
